// File: rtl/dv_scb_pkg.sv
// rtl/dv_scb_pkg.sv - shared types and helpers for the packet scoreboard
//
// Purpose: FSM state encoding plus popcount and saturating-add helpers used by
// dv_packet_scoreboard. Helpers operate on fixed maximum widths; callers
// zero-extend narrower vectors and truncate results back to their own width.
package dv_scb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scb_state_t;

    // Upper bounds on channel count and counter width accepted by the helpers.
    localparam int unsigned MAX_CH = 32;
    localparam int unsigned MAX_CW = 32;

    function automatic logic [5:0] popcount(input logic [MAX_CH-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // a + b clamped to the all-ones value of a cw-bit counter (cw < MAX_CW+1).
    function automatic logic [MAX_CW-1:0] sat_add(input logic [MAX_CW-1:0] a,
                                                  input logic [MAX_CW-1:0] b,
                                                  input int unsigned cw);
        logic [MAX_CW:0] one;
        logic [MAX_CW:0] sum;
        logic [MAX_CW:0] lim;
        one = {{MAX_CW{1'b0}}, 1'b1};
        sum = {1'b0, a} + {1'b0, b};
        lim = (one << cw) - one;
        return (sum > lim) ? lim[MAX_CW-1:0] : sum[MAX_CW-1:0];
    endfunction

endpackage

// File: rtl/dv_packet_scoreboard_if.sv
// rtl/dv_packet_scoreboard_if.sv - expected/dut packet bus of the scoreboard
//
// Purpose: bundles the per-channel expected-packet push port and the dut
// output observation port.
// Signals:
//   exp_access [N]     expected packet valid per channel
//   exp_packet [N*PW]  expected packets, channel i at [i*PW +: PW]
//   exp_wait   [N]     push refused (FIFO full or scoreboard done)
//   dut_access [N]     dut output valid per channel
//   dut_packet [N*PW]  dut output packets
// Modports: master = stimulus/dut side, slave = scoreboard.
interface dv_packet_scoreboard_if #(
    parameter int N  = 1,
    parameter int PW = 104
);
    logic [N-1:0]    exp_access;
    logic [N*PW-1:0] exp_packet;
    logic [N-1:0]    exp_wait;
    logic [N-1:0]    dut_access;
    logic [N*PW-1:0] dut_packet;

    modport master (
        output exp_access, exp_packet, dut_access, dut_packet,
        input  exp_wait
    );

    modport slave (
        input  exp_access, exp_packet, dut_access, dut_packet,
        output exp_wait
    );
endinterface

// File: rtl/dv_scb_fifo.sv
// rtl/dv_scb_fifo.sv - single-channel expected-packet FIFO
//
// Purpose: synchronous FIFO, PW wide and DEPTH deep (power of two, >= 2).
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   push        write push_data (ignored while full)
//   push_data   packet to queue
//   pop         drop the head entry (ignored while empty)
//   head        oldest queued entry
//   count       number of queued entries, 0..DEPTH
//   full        count == DEPTH
module dv_scb_fifo #(
    parameter int PW    = 104,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PW-1:0]              push_data,
    input  logic                       pop,
    output logic [PW-1:0]              head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dv_packet_scoreboard.sv
// rtl/dv_packet_scoreboard.sv - N-channel in-order packet scoreboard
//
// Purpose: queues expected packets per channel, compares dut output packets
// against the queue head under cmp_mask, counts matches/errors, and drives
// test_done/test_pass for the sim controller with a drain watchdog.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        level, IDLE -> RUN
//   stim_done    level, RUN -> DRAIN
//   cmp_mask     per-bit compare enable (1 = compare)
//   bus          expected/dut packet bus (slave modport)
//   match_count  saturating count of matching comparisons
//   err_count    saturating count of mismatches plus unexpected packets
//   err_flag     sticky per-channel error
//   test_done    high in DONE
//   test_pass    pass verdict, valid while test_done
//   timeout      DONE was reached by the drain watchdog
module dv_packet_scoreboard
    import dv_scb_pkg::*;
#(
    parameter int N       = 1,
    parameter int AW      = 32,
    parameter int PW      = 2*AW+40,
    parameter int DEPTH   = 16,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stim_done,
    input  logic [PW-1:0]          cmp_mask,
    dv_packet_scoreboard_if.slave  bus,
    output logic [CW-1:0]          match_count,
    output logic [CW-1:0]          err_count,
    output logic [N-1:0]           err_flag,
    output logic                   test_done,
    output logic                   test_pass,
    output logic                   timeout
);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int WDW  = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    scb_state_t       state;
    logic [WDW-1:0]   wd;
    logic             any_cmp_q;

    logic [PW-1:0]    head [N];
    logic [CNTW-1:0]  cnt  [N];
    logic [N-1:0]     full;
    logic [N-1:0]     empty;
    logic [N-1:0]     push;
    logic [N-1:0]     pop;
    logic [N-1:0]     match_v;
    logic [N-1:0]     mism_v;
    logic [N-1:0]     unexp_v;
    logic [N-1:0]     err_v;
    logic             cmp_active;
    logic             any_cmp;
    logic             all_empty;

    logic [MAX_CH-1:0] match_ext;
    logic [MAX_CH-1:0] err_ext;
    logic [MAX_CW-1:0] match_cur;
    logic [MAX_CW-1:0] err_cur;

    // Registered counts only: a pop this cycle never frees room for a push.
    assign bus.exp_wait = full | {N{state == DONE}};
    assign push         = bus.exp_access & ~bus.exp_wait;
    assign cmp_active   = (state == RUN) || (state == DRAIN);
    assign any_cmp      = cmp_active && (|bus.dut_access);
    assign err_v        = mism_v | unexp_v;
    assign all_empty    = &empty;

    for (genvar i = 0; i < N; i++) begin : g_ch
        dv_scb_fifo #(
            .PW    (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[i]),
            .push_data (bus.exp_packet[i*PW +: PW]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (cnt[i]),
            .full      (full[i])
        );
        assign empty[i] = (cnt[i] == '0);
    end

    // Emptiness comes from the registered count, so a packet pushed this
    // cycle cannot satisfy a same-cycle dut packet: that one is unexpected.
    always_comb begin
        pop     = '0;
        match_v = '0;
        mism_v  = '0;
        unexp_v = '0;
        for (int i = 0; i < N; i++) begin
            if (cmp_active && bus.dut_access[i]) begin
                if (empty[i]) begin
                    unexp_v[i] = 1'b1;
                end else begin
                    pop[i] = 1'b1;
                    if (((bus.dut_packet[i*PW +: PW] ^ head[i]) & cmp_mask) == '0)
                        match_v[i] = 1'b1;
                    else
                        mism_v[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        match_ext          = '0;
        err_ext            = '0;
        match_cur          = '0;
        err_cur            = '0;
        match_ext[N-1:0]   = match_v;
        err_ext[N-1:0]     = err_v;
        match_cur[CW-1:0]  = match_count;
        err_cur[CW-1:0]    = err_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
            err_count   <= '0;
            err_flag    <= '0;
        end else begin
            match_count <= CW'(sat_add(match_cur,
                               {{(MAX_CW-6){1'b0}}, popcount(match_ext)}, CW));
            err_count   <= CW'(sat_add(err_cur,
                               {{(MAX_CW-6){1'b0}}, popcount(err_ext)}, CW));
            err_flag    <= err_flag | err_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wd        <= '0;
            any_cmp_q <= 1'b0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            any_cmp_q <= any_cmp;
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (stim_done) begin
                        state <= DRAIN;
                        wd    <= '0;
                    end
                end
                DRAIN: begin
                    // Normal completion wins over the watchdog. Errors found
                    // in this very cycle land in err_count one cycle later,
                    // so they are folded into the verdict here.
                    if (all_empty && !any_cmp_q) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                        test_pass <= (err_count == '0) && !(|err_v) && all_empty;
                    end else if (any_cmp) begin
                        wd <= '0;
                    end else if (wd == WD_LAST) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                        test_pass <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dv_packet_scoreboard.sv
// tb/tb_dv_packet_scoreboard.sv - directed self-checking bench for dv_packet_scoreboard
module tb_dv_packet_scoreboard;
    localparam int N       = 2;
    localparam int PW      = 104;
    localparam int DEPTH   = 4;
    localparam int CW      = 4;
    localparam int TIMEOUT = 20;
    localparam logic [PW-1:0] FULL_MASK = {PW{1'b1}};
    localparam logic [PW-1:0] Z = '0;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stim_done;
    logic [PW-1:0] cmp_mask;
    logic [CW-1:0] match_count;
    logic [CW-1:0] err_count;
    logic [N-1:0]  err_flag;
    logic          test_done;
    logic          test_pass;
    logic          timeout;

    int n_assert;
    int n_fail;
    int n_cyc;

    dv_packet_scoreboard_if #(.N(N), .PW(PW)) bus ();

    dv_packet_scoreboard #(
        .N(N), .AW(32), .PW(PW), .DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stim_done   (stim_done),
        .cmp_mask    (cmp_mask),
        .bus         (bus),
        .match_count (match_count),
        .err_count   (err_count),
        .err_flag    (err_flag),
        .test_done   (test_done),
        .test_pass   (test_pass),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start          = 1'b0;
        stim_done      = 1'b0;
        cmp_mask       = FULL_MASK;
        bus.exp_access = '0;
        bus.exp_packet = '0;
        bus.dut_access = '0;
        bus.dut_packet = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && !test_done; i++) tick();
        check("wait_done", {31'd0, test_done}, 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_match",   {28'd0, match_count}, 32'd0);
        check("rst_err",     {28'd0, err_count},   32'd0);
        check("rst_flag",    {30'd0, err_flag},    32'd0);
        check("rst_done",    {31'd0, test_done},   32'd0);
        check("rst_pass",    {31'd0, test_pass},   32'd0);
        check("rst_timeout", {31'd0, timeout},     32'd0);
        check("rst_wait",    {30'd0, bus.exp_wait}, 32'd0);

        // Two in-order matches on channel 0, then a clean drain.
        start = 1'b1;
        bus.exp_access = 2'b01;
        bus.exp_packet = {Z, 104'h11};
        tick();
        bus.exp_packet = {Z, 104'h22};
        tick();
        bus.exp_access = 2'b00;
        bus.dut_access = 2'b01;
        bus.dut_packet = {Z, 104'h11};
        tick();
        check("s1_match1", {28'd0, match_count}, 32'd1);
        bus.dut_packet = {Z, 104'h22};
        tick();
        bus.dut_access = 2'b00;
        check("s1_match2", {28'd0, match_count}, 32'd2);
        check("s1_err",    {28'd0, err_count},   32'd0);
        stim_done = 1'b1;
        wait_done(10);
        check("s1_pass",    {31'd0, test_pass},    32'd1);
        check("s1_timeout", {31'd0, timeout},      32'd0);
        check("s1_wait",    {30'd0, bus.exp_wait}, 32'd3);
        bus.dut_access = 2'b01;
        tick();
        bus.dut_access = 2'b00;
        check("s1_done_ign_err",   {28'd0, err_count},   32'd0);
        check("s1_done_ign_match", {28'd0, match_count}, 32'd2);

        // Masked compare ignores the low byte; full mask reports it.
        do_reset();
        start = 1'b1;
        tick();
        bus.exp_access = 2'b01;
        bus.exp_packet = {Z, 104'h1234};
        tick();
        bus.exp_access = 2'b00;
        cmp_mask       = ~104'hFF;
        bus.dut_access = 2'b01;
        bus.dut_packet = {Z, 104'h12FF};
        tick();
        bus.dut_access = 2'b00;
        check("s2_mask_match", {28'd0, match_count}, 32'd1);
        check("s2_mask_err",   {28'd0, err_count},   32'd0);
        cmp_mask       = FULL_MASK;
        bus.exp_access = 2'b01;
        bus.exp_packet = {Z, 104'h1234};
        tick();
        bus.exp_access = 2'b00;
        bus.dut_access = 2'b01;
        bus.dut_packet = {Z, 104'h12FF};
        tick();
        bus.dut_access = 2'b00;
        check("s2_full_err",   {28'd0, err_count},   32'd1);
        check("s2_full_flag",  {30'd0, err_flag},    32'd1);
        check("s2_full_match", {28'd0, match_count}, 32'd1);
        stim_done = 1'b1;
        wait_done(10);
        check("s2_pass",    {31'd0, test_pass}, 32'd0);
        check("s2_timeout", {31'd0, timeout},   32'd0);

        // Unexpected dut packet on ch1 in the same cycle as a ch1 push.
        do_reset();
        start = 1'b1;
        tick();
        bus.exp_access = 2'b10;
        bus.exp_packet = {104'h55, Z};
        bus.dut_access = 2'b10;
        bus.dut_packet = {104'h55, Z};
        tick();
        bus.exp_access = 2'b00;
        bus.dut_access = 2'b00;
        check("s3_err",   {28'd0, err_count},   32'd1);
        check("s3_flag",  {30'd0, err_flag},    32'd2);
        check("s3_match", {28'd0, match_count}, 32'd0);
        bus.dut_access = 2'b10;
        tick();
        bus.dut_access = 2'b00;
        check("s3_queued_match", {28'd0, match_count}, 32'd1);
        check("s3_queued_err",   {28'd0, err_count},   32'd1);

        // Fill ch0: wait rises after the 4th push, the 5th is dropped.
        do_reset();
        start = 1'b1;
        tick();
        bus.exp_access = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            bus.exp_packet = {Z, 104'(k)};
            tick();
            check("s4_fill_wait", {30'd0, bus.exp_wait}, (k >= 4) ? 32'd1 : 32'd0);
        end
        bus.exp_access = 2'b00;
        bus.dut_access = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            bus.dut_packet = {Z, 104'(k)};
            tick();
            check("s4_pop_match", {28'd0, match_count}, 32'(k));
            check("s4_pop_wait",  {30'd0, bus.exp_wait}, 32'd0);
        end
        bus.dut_packet = {Z, 104'd5};
        tick();
        bus.dut_access = 2'b00;
        check("s4_fifth_refused", {28'd0, err_count}, 32'd1);

        // Full FIFO, no dut traffic: watchdog ends DRAIN after TIMEOUT cycles.
        do_reset();
        start = 1'b1;
        tick();
        bus.exp_access = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            bus.exp_packet = {Z, 104'(k)};
            tick();
        end
        bus.exp_access = 2'b00;
        stim_done = 1'b1;
        tick();
        n_cyc = 0;
        while (!test_done && n_cyc < 100) begin
            tick();
            n_cyc++;
        end
        check("s5_drain_cycles", 32'(n_cyc), 32'(TIMEOUT));
        check("s5_done",    {31'd0, test_done}, 32'd1);
        check("s5_timeout", {31'd0, timeout},   32'd1);
        check("s5_pass",    {31'd0, test_pass}, 32'd0);

        // Both channels matching each cycle: +2 per cycle, saturating at 15.
        do_reset();
        start = 1'b1;
        tick();
        bus.exp_access = 2'b11;
        bus.exp_packet = {104'd0, 104'd0};
        tick();
        for (int k = 1; k <= 10; k++) begin
            bus.dut_access = 2'b11;
            bus.dut_packet = {104'(k-1), 104'(k-1)};
            if (k <= 9) begin
                bus.exp_access = 2'b11;
                bus.exp_packet = {104'(k), 104'(k)};
            end else begin
                bus.exp_access = 2'b00;
            end
            tick();
            check("s6_sat_match", {28'd0, match_count}, (2*k > 15) ? 32'd15 : 32'(2*k));
        end
        bus.dut_access = 2'b00;
        check("s6_err", {28'd0, err_count}, 32'd0);

        // Reset in RUN with three entries queued and an error recorded.
        do_reset();
        start = 1'b1;
        tick();
        bus.exp_access = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            bus.exp_packet = {Z, 104'(k)};
            if (k == 3) bus.dut_access = 2'b10;
            tick();
        end
        bus.exp_access = 2'b00;
        bus.dut_access = 2'b00;
        check("s7_pre_err", {28'd0, err_count}, 32'd1);
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s7_wait",  {30'd0, bus.exp_wait}, 32'd0);
        check("s7_match", {28'd0, match_count},  32'd0);
        check("s7_err",   {28'd0, err_count},    32'd0);
        check("s7_flag",  {30'd0, err_flag},     32'd0);
        check("s7_done",  {31'd0, test_done},    32'd0);
        bus.dut_access = 2'b01;
        bus.dut_packet = {Z, 104'd1};
        tick();
        bus.dut_access = 2'b00;
        check("s7_idle_ignore", {28'd0, err_count}, 32'd0);
        start = 1'b1;
        tick();
        bus.dut_access = 2'b01;
        tick();
        bus.dut_access = 2'b00;
        check("s7_fifo_cleared_err",   {28'd0, err_count},   32'd1);
        check("s7_fifo_cleared_match", {28'd0, match_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
